// File: rtl/gps_ca_acquire.sv
// GPS C/A code acquisition: generates the selected PRN locally and reports the
// first 13-chip window offset whose Hamming distance to the received word is within max_err.
module gps_ca_acquire #(
  parameter logic [9:0] SEARCH_LAST = 10'd1022
) (
  input  logic        sys_clk_50,
  input  logic        rst_n_in,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  sv_num,
  input  logic [12:0] ca_word,
  input  logic [3:0]  max_err,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        sv_err,
  output logic [9:0]  code_phase,
  output logic [3:0]  err_count
);

  // state  | meaning
  // IDLE   | waiting for start
  // FILL   | shifting the first 13 local chips into the window
  // SEARCH | comparing one window offset per cycle
  // DONE   | result published; illegal PRN waits here one extra cycle
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEARCH, S_DONE} state_t;

  state_t      state_q;
  logic [10:1] g1_q, g2_q;
  logic [12:0] win_q;
  logic [12:0] word_q;
  logic [5:0]  sv_q;
  logic [3:0]  max_err_q;
  logic [3:0]  fill_cnt_q;
  logic [9:0]  k_q;
  logic        busy_q, done_q, found_q, sv_err_q;
  logic [9:0]  phase_q;
  logic [3:0]  err_q;

  logic [7:0]  taps;
  logic [3:0]  tap_a, tap_b;
  logic        chip, hit, sv_ok;
  logic [3:0]  mismatch;
  logic [10:1] g1_d, g2_d;
  logic [12:0] win_d;

  always_comb begin
    taps = 8'h12;
    case (sv_q)
      6'd1:  taps = 8'h26;
      6'd2:  taps = 8'h37;
      6'd3:  taps = 8'h48;
      6'd4:  taps = 8'h59;
      6'd5:  taps = 8'h19;
      6'd6:  taps = 8'h2A;
      6'd7:  taps = 8'h18;
      6'd8:  taps = 8'h29;
      6'd9:  taps = 8'h3A;
      6'd10: taps = 8'h23;
      6'd11: taps = 8'h34;
      6'd12: taps = 8'h56;
      6'd13: taps = 8'h67;
      6'd14: taps = 8'h78;
      6'd15: taps = 8'h89;
      6'd16: taps = 8'h9A;
      6'd17: taps = 8'h14;
      6'd18: taps = 8'h25;
      6'd19: taps = 8'h36;
      6'd20: taps = 8'h47;
      6'd21: taps = 8'h58;
      6'd22: taps = 8'h69;
      6'd23: taps = 8'h13;
      6'd24: taps = 8'h46;
      6'd25: taps = 8'h57;
      6'd26: taps = 8'h68;
      6'd27: taps = 8'h79;
      6'd28: taps = 8'h8A;
      6'd29: taps = 8'h16;
      6'd30: taps = 8'h27;
      6'd31: taps = 8'h38;
      6'd32: taps = 8'h49;
      default: taps = 8'h12;
    endcase
  end

  // Tap pairs are packed as two stage numbers, 1..10 (A = stage 10).
  assign tap_a    = taps[7:4];
  assign tap_b    = taps[3:0];
  assign chip     = g1_q[10] ^ g2_q[tap_a] ^ g2_q[tap_b];
  assign g1_d     = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
  assign g2_d     = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
  assign win_d    = {win_q[11:0], chip};
  assign mismatch = 4'($countones(win_q ^ word_q));
  assign hit      = (mismatch <= max_err_q);
  assign sv_ok    = (sv_num != 6'd0) && (sv_num <= 6'd32);

  always_ff @(posedge sys_clk_50 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      g1_q       <= '1;
      g2_q       <= '1;
      win_q      <= '0;
      word_q     <= '0;
      sv_q       <= '0;
      max_err_q  <= '0;
      fill_cnt_q <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      sv_err_q   <= 1'b0;
      phase_q    <= '0;
      err_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sv_q       <= sv_num;
            word_q     <= ca_word;
            max_err_q  <= max_err;
            g1_q       <= '1;
            g2_q       <= '1;
            win_q      <= '0;
            fill_cnt_q <= 4'd12;
            k_q        <= '0;
            found_q    <= 1'b0;
            sv_err_q   <= 1'b0;
            phase_q    <= '0;
            err_q      <= '0;
            if (sv_ok) begin
              state_q <= S_FILL;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_FILL: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            g1_q  <= g1_d;
            g2_q  <= g2_d;
            win_q <= win_d;
            if (fill_cnt_q == 4'd0) state_q <= S_SEARCH;
            else fill_cnt_q <= fill_cnt_q - 4'd1;
          end
        end
        S_SEARCH: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (hit) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            found_q <= 1'b1;
            phase_q <= k_q;
            err_q   <= mismatch;
          end else if (k_q == SEARCH_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            g1_q  <= g1_d;
            g2_q  <= g2_d;
            win_q <= win_d;
            k_q   <= k_q + 10'd1;
          end
        end
        S_DONE: begin
          // Arriving with done low means an illegal PRN: publish it one cycle later.
          if (done_q) begin
            state_q <= S_IDLE;
          end else begin
            done_q   <= 1'b1;
            sv_err_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign sv_err     = sv_err_q;
  assign code_phase = phase_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_gps_ca_acquire.sv
// Bench for gps_ca_acquire: directed search table scored against a C/A model built
// from the G2 delay table, plus abort, reset and start-while-busy sequences.
`timescale 1ns/1ps
module tb_gps_ca_acquire;
  localparam int LAST  = 1022;
  localparam int LIMIT = 1100;

  logic        sys_clk_50 = 1'b0;
  logic        rst_n_in   = 1'b0;
  logic        start      = 1'b0;
  logic        abort      = 1'b0;
  logic [5:0]  sv_num     = '0;
  logic [12:0] ca_word    = '0;
  logic [3:0]  max_err    = '0;
  logic        busy, done, found, sv_err;
  logic [9:0]  code_phase;
  logic [3:0]  err_count;

  int checks   = 0;
  int failures = 0;

  gps_ca_acquire #(.SEARCH_LAST(10'd1022)) dut (
    .sys_clk_50(sys_clk_50), .rst_n_in(rst_n_in), .start(start), .abort(abort),
    .sv_num(sv_num), .ca_word(ca_word), .max_err(max_err),
    .busy(busy), .done(done), .found(found), .sv_err(sv_err),
    .code_phase(code_phase), .err_count(err_count)
  );

  always #10 sys_clk_50 = ~sys_clk_50;

  typedef struct {
    logic [5:0]  sv;
    logic [12:0] word;
    logic [3:0]  me;
    logic        exp_found;
    logic        exp_sv_err;
    int          exp_phase;
    int          exp_err;
    int          exp_edge;
  } vec_t;

  vec_t vecs[11];
  int   g1s[1023];
  int   g2s[1023];
  int   g2_delay[33] = '{0, 5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                         469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};

  // Base sequences as output-bit recurrences, starting from the all-ones register state.
  function automatic void build_base();
    int x[1033];
    int y[1033];
    for (int t = 0; t < 10; t++) begin x[t] = 1; y[t] = 1; end
    for (int t = 0; t < 1023; t++) begin
      x[t+10] = x[t+7] ^ x[t];
      y[t+10] = y[t+8] ^ y[t+7] ^ y[t+4] ^ y[t+2] ^ y[t+1] ^ y[t];
    end
    for (int t = 0; t < 1023; t++) begin g1s[t] = x[t]; g2s[t] = y[t]; end
  endfunction

  function automatic int ca_chip(int p, int t);
    return g1s[t % 1023] ^ g2s[(t - g2_delay[p] + 2046) % 1023];
  endfunction

  function automatic logic [12:0] window(int p, int k);
    logic [12:0] w;
    for (int i = 0; i < 13; i++) w[12-i] = (ca_chip(p, k + i) != 0);
    return w;
  endfunction

  function automatic int model_search(int p, logic [12:0] word, int me, output int e);
    int mm;
    e = 0;
    for (int k = 0; k <= LAST; k++) begin
      mm = $countones(window(p, k) ^ word);
      if (mm <= me) begin e = mm; return k; end
    end
    return -1;
  endfunction

  function automatic vec_t make_vec(int sv, logic [12:0] word, int me);
    vec_t v;
    int   k;
    int   e;
    v.sv = 6'(sv); v.word = word; v.me = 4'(me);
    v.exp_found = 1'b0; v.exp_sv_err = 1'b0; v.exp_phase = 0; v.exp_err = 0;
    if (sv < 1 || sv > 32) begin
      v.exp_sv_err = 1'b1; v.exp_edge = 1;
    end else begin
      k = model_search(sv, word, me, e);
      if (k >= 0) begin
        v.exp_found = 1'b1; v.exp_phase = k; v.exp_err = e; v.exp_edge = k + 14;
      end else begin
        v.exp_edge = LAST + 14;
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic kick(input logic [5:0] s, input logic [12:0] w, input logic [3:0] m, input logic ab);
    @(negedge sys_clk_50);
    sv_num = s; ca_word = w; max_err = m; start = 1'b1; abort = ab;
    @(posedge sys_clk_50); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edge_n);
    edge_n = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge sys_clk_50); #1;
      if (done === 1'b1) begin edge_n = n; break; end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e;
    kick(v.sv, v.word, v.me, 1'b0);
    chk($sformatf("v%0d_busy_at_start", idx), busy, v.exp_sv_err ? 0 : 1);
    chk($sformatf("v%0d_found_cleared", idx), found, 0);
    chk($sformatf("v%0d_phase_cleared", idx), code_phase, 0);
    wait_done(LIMIT, e);
    chk($sformatf("v%0d_done_edge", idx), e, v.exp_edge);
    chk($sformatf("v%0d_found", idx), found, v.exp_found);
    chk($sformatf("v%0d_sv_err", idx), sv_err, v.exp_sv_err);
    chk($sformatf("v%0d_code_phase", idx), code_phase, v.exp_phase);
    chk($sformatf("v%0d_err_count", idx), err_count, v.exp_err);
    chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
    @(posedge sys_clk_50); #1;
    chk($sformatf("v%0d_done_pulse", idx), done, 0);
    chk($sformatf("v%0d_found_held", idx), found, v.exp_found);
    chk($sformatf("v%0d_sv_err_held", idx), sv_err, v.exp_sv_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] w7;
    logic [12:0] nm;
    int          dummy;
    int          e;
    int          ndone;

    build_base();
    w7 = window(7, 500);
    nm = '0;
    for (int w = 0; w < 8192; w++) begin
      if (model_search(12, 13'(w), 0, dummy) < 0) begin nm = 13'(w); break; end
    end

    vecs[0]  = '{6'd1,  window(1, 0), 4'd0, 1'b1, 1'b0, 0, 0, 14};
    vecs[1]  = make_vec(7, w7, 0);
    vecs[2]  = make_vec(7, w7 ^ 13'h0204, 2);
    vecs[3]  = make_vec(7, w7 ^ 13'h0204, 1);
    vecs[4]  = make_vec(20, window(20, 1020), 0);
    vecs[5]  = '{6'd0,  13'h1555, 4'd3, 1'b0, 1'b1, 0, 0, 1};
    vecs[6]  = '{6'd33, 13'h0AAA, 4'd0, 1'b0, 1'b1, 0, 0, 1};
    vecs[7]  = make_vec(5, 13'h0ABC, 13);
    vecs[8]  = make_vec(32, window(32, 1022), 0);
    vecs[9]  = '{6'd63, 13'h1FFF, 4'd15, 1'b0, 1'b1, 0, 0, 1};
    vecs[10] = make_vec(12, nm, 0);

    #5;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_found", found, 0);
    chk("reset_sv_err", sv_err, 0);
    chk("reset_code_phase", code_phase, 0);
    chk("reset_err_count", err_count, 0);
    repeat (2) @(negedge sys_clk_50);
    rst_n_in = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // start pulsed mid-search with different inputs must not disturb the search
    kick(6'd7, w7, 4'd0, 1'b0);
    repeat (19) @(posedge sys_clk_50);
    #1;
    sv_num = 6'd1; ca_word = window(1, 0); max_err = 4'd13; start = 1'b1;
    @(posedge sys_clk_50); #1;
    start = 1'b0;
    wait_done(LIMIT, e);
    chk("ignore_start_done_edge", e + 20, vecs[1].exp_edge);
    chk("ignore_start_phase", code_phase, vecs[1].exp_phase);
    chk("ignore_start_found", found, 1);
    @(posedge sys_clk_50); #1;

    // start and abort together in IDLE: start wins
    kick(6'd1, window(1, 0), 4'd0, 1'b1);
    chk("start_abort_busy", busy, 1);
    wait_done(LIMIT, e);
    chk("start_abort_done_edge", e, 14);
    chk("start_abort_found", found, 1);
    @(posedge sys_clk_50); #1;

    // abort at edge 200
    kick(6'd7, w7, 4'd0, 1'b0);
    repeat (199) @(posedge sys_clk_50);
    #1;
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge sys_clk_50); #1;
    abort = 1'b0;
    chk("abort_busy_after", busy, 0);
    chk("abort_found", found, 0);
    chk("abort_code_phase", code_phase, 0);
    chk("abort_err_count", err_count, 0);
    ndone = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge sys_clk_50); #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // asynchronous reset clears held results without waiting for a clock
    run_vec(vecs[1], 11);
    @(negedge sys_clk_50); #3;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_found", found, 0);
    chk("async_rst_code_phase", code_phase, 0);
    chk("async_rst_err_count", err_count, 0);
    @(negedge sys_clk_50);
    rst_n_in = 1'b1;

    // reset at edge 300 of a search, then a fresh search
    kick(6'd7, w7, 4'd0, 1'b0);
    repeat (299) @(posedge sys_clk_50);
    #1;
    chk("midrst_busy_before", busy, 1);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    ndone = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge sys_clk_50); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("midrst_quiet", ndone, 0);
    @(negedge sys_clk_50);
    rst_n_in = 1'b1;
    ndone = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge sys_clk_50); #1;
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_vec(vecs[0], 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gps_ca_acquire.md
GPS_CA_ACQUIRE -- requirements
Module: gps_ca_acquire

Interface
REQ-001 Parameter SEARCH_LAST, default 10'd1022, last code offset searched (legal range 0..1022).
REQ-002 sys_clk_50  input  1  sole clock; all state on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin search; sampled only in IDLE.
REQ-005 abort  input  1  cancel search in progress.
REQ-006 sv_num  input  6  PRN select, valid 1..32; latched on start.
REQ-007 ca_word  input  13  received C/A chips; bit 12 is the earliest chip; latched on start.
REQ-008 max_err  input  4  maximum allowed Hamming mismatches; latched on start.
REQ-009 busy  output  1  high in FILL or SEARCH.
REQ-010 done  output  1  one-cycle pulse when a search completes.
REQ-011 found  output  1  match located; valid from done and held until the next accepted start.
REQ-012 sv_err  output  1  latched sv_num was illegal; held until the next accepted start.
REQ-013 code_phase  output  10  offset k of the matching window.
REQ-014 err_count  output  4  mismatch count of the matching window.

Function
REQ-015 The block SHALL implement the states IDLE, FILL, SEARCH and DONE.
- IDLE -> FILL on start.
- FILL -> SEARCH after 13 chips.
- SEARCH -> DONE on match or after offset SEARCH_LAST.
- DONE -> IDLE after 1 cycle.
REQ-016 The local C/A generator SHALL produce chips per IS-GPS-200.
- G1: 10-bit LFSR, feedback from stages 3 and 10.
- G2: 10-bit LFSR, feedback from stages 2, 3, 6, 8, 9 and 10.
- Both registers are loaded to all ones on an accepted start.
- chip = G1[10] xor G2[tapA] xor G2[tapB], using the PRN 1-32 phase-select pairs of IS-GPS-200 Table 3-Ia.
REQ-017 Chip j (0-based) SHALL shift into a 13-bit window register on the (j+1)th edge after the start edge; the oldest chip is bit 12.
REQ-018 Window offset k SHALL cover chips k..k+12; LFSRs free-run past chip 1022, so windows wrap naturally over the 1023-chip period.
REQ-019 Mismatch SHALL equal the popcount of (window xor latched ca_word), a 4-bit value from 0 to 13.
REQ-020 The match rule SHALL be the lowest k, 0..SEARCH_LAST, with mismatch <= max_err; the search stops at the first match.
REQ-021 Match at offset k: done, found=1, code_phase=k and err_count=mismatch SHALL all assert on edge k+14 after the start edge.
REQ-022 No match: done SHALL pulse on edge SEARCH_LAST+14 with found=0, code_phase=0 and err_count=0.
REQ-023 sv_num of 0 or greater than 32 SHALL skip FILL and SEARCH: done and sv_err=1 on edge 1, found=0.
REQ-024 An accepted start SHALL clear found, sv_err, code_phase and err_count on the same edge.
REQ-025 start while busy or in DONE SHALL be ignored; inputs are not relatched.
REQ-026 abort in FILL or SEARCH SHALL return the block to IDLE on the next edge with no done pulse and all result outputs cleared; abort in IDLE or DONE has no effect.
REQ-027 When start and abort are high in the same IDLE cycle, start SHALL win.
REQ-028 max_err >= 13 SHALL match at k=0.

Reset
REQ-029 rst_n_in low SHALL immediately force IDLE and clear busy, done, found, sv_err, code_phase, err_count, the window and the latched inputs.
REQ-030 The LFSRs SHALL reset to all ones.
REQ-031 Reset asserted mid-search SHALL discard the search, with no done pulse.
REQ-032 Reset release SHALL be followed by normal IDLE behaviour from the first clock edge.

Verification
REQ-033 sv_num=1, ca_word = golden PRN1 chips 0..12 (top 10 bits 1100100000), max_err=0 -> done on edge 14, found=1, code_phase=0, err_count=0.
REQ-034 sv_num=7, ca_word = golden PRN7 chips 500..512, max_err=0 -> done on edge 514, code_phase=500.
REQ-035 Same as REQ-034 with 2 bits flipped and max_err=2 -> found=1, code_phase=500 (or a lower k per golden model), err_count <= 2; with max_err=1 -> match at the golden-model k, or no match with done on edge 1036.
REQ-036 sv_num=0 -> done and sv_err on edge 1; sv_num=33 -> same.
REQ-037 Golden window wrapping chips 1020..1022,0..9 -> code_phase=1020.
REQ-038 Abort at edge 200 -> no done pulse, busy low on edge 201; rst_n_in low at edge 300 of a new search -> outputs 0 immediately; a new start after release works.
